// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        DIV_WAIT = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO        = 5'd0;
    localparam int         DIV_LAT_DEFAULT = 32;

endpackage

// File: rtl/div_wait_timer.sv
// Down-counter that times the divider occupancy of EX.
// Latency: load takes effect next cycle; zero flag is combinational from the count.
// Backpressure: none; dec is ignored once the count reaches zero.
module div_wait_timer #(
    parameter int DIV_LAT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int            CW       = $clog2(DIV_LAT + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(DIV_LAT - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - ONE;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller: load-use stall, taken-transfer fetch flush, divider freeze.
// Latency: hazard responses combinational; a divide freezes the front end DIV_LAT cycles.
// Backpressure: drives PC / IF/ID / ID/EX enables low to hold the front end.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_LAT = DIV_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs_addr,
    input  logic [4:0]  id_rt_addr,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_isGoto,
    input  logic [4:0]  ex_regfiles_waddr,
    input  logic        ex_w_regfiles,
    input  logic        ex_mem_read,
    input  logic        ex_div,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_en,
    output logic        id_ex_flush,
    output logic        div_start,
    output logic        div_busy,
    output logic [31:0] stall_cycles
);

    state_t state_q;
    state_t state_d;
    logic   load_use;
    logic   resolve;
    logic   timer_load;
    logic   timer_dec;
    logic   timer_zero;

    assign load_use = ex_mem_read && ex_w_regfiles && (ex_regfiles_waddr != REG_ZERO) &&
                      ((id_uses_rs && (id_rs_addr == ex_regfiles_waddr)) ||
                       (id_uses_rt && (id_rt_addr == ex_regfiles_waddr)));

    div_wait_timer #(
        .DIV_LAT(DIV_LAT)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .dec  (timer_dec),
        .zero (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b0;
        div_start   = 1'b0;
        div_busy    = 1'b0;
        timer_load  = 1'b0;
        timer_dec   = 1'b0;
        resolve     = 1'b0;

        case (state_q)
            RUN: begin
                if (ex_div) begin
                    div_start  = 1'b1;
                    pc_en      = 1'b0;
                    if_id_en   = 1'b0;
                    id_ex_en   = 1'b0;
                    timer_load = 1'b1;
                    state_d    = DIV_WAIT;
                end else begin
                    resolve = 1'b1;
                end
            end
            DIV_WAIT: begin
                div_busy = 1'b1;
                if (!timer_zero) begin
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    id_ex_en  = 1'b0;
                    timer_dec = 1'b1;
                end else begin
                    // Release cycle: the divide is still in EX, so ex_div is not re-sampled.
                    resolve = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        // Load-use wins over a taken transfer; the branch re-resolves once its operand arrives.
        if (resolve) begin
            if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end else if (id_isGoto) begin
                if_id_flush = 1'b1;
            end
        end

        if (!rst) begin
            state_d     = RUN;
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            if_id_flush = 1'b0;
            id_ex_en    = 1'b1;
            id_ex_flush = 1'b0;
            div_start   = 1'b0;
            div_busy    = 1'b0;
            timer_load  = 1'b0;
            timer_dec   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles <= 32'd0;
        end else if (!pc_en) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a 4-cycle divider.
// Inputs change 1 time unit after posedge; outputs are sampled on the falling edge.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs_addr, id_rt_addr, ex_regfiles_waddr;
    logic        id_uses_rs, id_uses_rt, id_isGoto;
    logic        ex_w_regfiles, ex_mem_read, ex_div;
    logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, div_start, div_busy;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, div_start, div_busy}
    localparam logic [6:0] IDLE  = 7'b1101000;
    localparam logic [6:0] LUSE  = 7'b0001100;
    localparam logic [6:0] GOTO  = 7'b1111000;
    localparam logic [6:0] START = 7'b0000010;
    localparam logic [6:0] WAIT  = 7'b0000001;
    localparam logic [6:0] REL   = 7'b1101001;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.DIV_LAT(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .id_rs_addr        (id_rs_addr),
        .id_rt_addr        (id_rt_addr),
        .id_uses_rs        (id_uses_rs),
        .id_uses_rt        (id_uses_rt),
        .id_isGoto         (id_isGoto),
        .ex_regfiles_waddr (ex_regfiles_waddr),
        .ex_w_regfiles     (ex_w_regfiles),
        .ex_mem_read       (ex_mem_read),
        .ex_div            (ex_div),
        .pc_en             (pc_en),
        .if_id_en          (if_id_en),
        .if_id_flush       (if_id_flush),
        .id_ex_en          (id_ex_en),
        .id_ex_flush       (id_ex_flush),
        .div_start         (div_start),
        .div_busy          (div_busy),
        .stall_cycles      (stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [6:0] exp);
        chk(tag, {25'd0, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, div_start, div_busy},
            {25'd0, exp});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs_addr = 5'd0; id_rt_addr = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_isGoto = 1'b0; ex_regfiles_waddr = 5'd0; ex_w_regfiles = 1'b0;
        ex_mem_read = 1'b0; ex_div = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] waddr);
        ex_mem_read = 1'b1; ex_w_regfiles = 1'b1; ex_regfiles_waddr = waddr;
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        ex_div = 1'b1;
        @(negedge clk);
        chk_out("reset_forced", IDLE);
        next_cycle();
        rst = 1'b1;
        ex_div = 1'b0;
        @(negedge clk);
        chk_out("idle_after_reset", IDLE);
        chk("stall_reset", stall_cycles, 32'd0);

        // load-use on rs
        next_cycle();
        set_load(5'd8); id_uses_rs = 1'b1; id_rs_addr = 5'd8;
        @(negedge clk);
        chk_out("load_use_rs", LUSE);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        chk_out("after_load_use", IDLE);
        chk("stall_after_lu", stall_cycles, 32'd1);

        // load to $0 never stalls
        next_cycle();
        set_load(5'd0); id_uses_rs = 1'b1; id_uses_rt = 1'b1;
        @(negedge clk);
        chk_out("load_r0", IDLE);

        // rt matches but is not read
        next_cycle();
        clear_inputs();
        set_load(5'd8); id_rt_addr = 5'd8; id_rs_addr = 5'd3; id_uses_rs = 1'b1;
        @(negedge clk);
        chk_out("rt_unused", IDLE);

        // rt match that is read
        next_cycle();
        id_uses_rt = 1'b1;
        @(negedge clk);
        chk_out("load_use_rt", LUSE);

        // matching load that does not write the register file
        next_cycle();
        ex_w_regfiles = 1'b0;
        @(negedge clk);
        chk_out("load_no_write", IDLE);
        chk("stall_two", stall_cycles, 32'd2);

        // taken transfer, no hazard
        next_cycle();
        clear_inputs();
        id_isGoto = 1'b1;
        @(negedge clk);
        chk_out("goto_flush", GOTO);

        // taken transfer behind a load-use
        next_cycle();
        set_load(5'd9); id_uses_rs = 1'b1; id_rs_addr = 5'd9;
        @(negedge clk);
        chk_out("goto_lu_stall", LUSE);
        next_cycle();
        ex_mem_read = 1'b0; ex_w_regfiles = 1'b0;
        @(negedge clk);
        chk_out("goto_reresolve", GOTO);
        chk("stall_three", stall_cycles, 32'd3);

        // divide at T, DIV_LAT = 4
        next_cycle();
        clear_inputs();
        ex_div = 1'b1;
        @(negedge clk);
        chk_out("div_T", START);
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
            @(negedge clk);
            chk_out($sformatf("div_wait_%0d", i), WAIT);
        end
        next_cycle();
        @(negedge clk);
        chk_out("div_release", REL);
        chk("stall_div", stall_cycles, 32'd7);

        // back-to-back divide restarts with a fresh start pulse
        next_cycle();
        @(negedge clk);
        chk_out("div2_T", START);
        next_cycle();
        @(negedge clk);
        chk_out("div2_wait", WAIT);

        // reset at T+2 abandons the sequence
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk_out("div2_reset_forced", IDLE);
        chk("stall_before_reset", stall_cycles, 32'd9);
        next_cycle();
        rst = 1'b1;
        ex_div = 1'b0;
        @(negedge clk);
        chk_out("post_reset_run", IDLE);
        chk("stall_cleared", stall_cycles, 32'd0);
        next_cycle();
        @(negedge clk);
        chk_out("no_stray_start", IDLE);
        chk("stall_still_zero", stall_cycles, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Stall/flush controller for the five-stage pipeline; drives the enables and bubble controls of the PC, IF/ID and ID/EX registers. Detects load-use hazards between ID and EX and flushes the wrong-path fetch on ID-resolved control transfers (no delay slot). Sequences the multi-cycle divider by freezing the front end while a divide occupies EX. Sits beside the decoder; all outputs feed pipeline-register controls and the divider.

## Interface
- DIV_LAT, 32: divider latency in cycles; legal range 1..63.
- clk  in  1  pipeline clock.
- rst  in  1  reset; one clock; reset is synchronous and active-low.
- id_rs_addr, id_rt_addr  in  5 each  source register numbers of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads rs / rt.
- id_isGoto  in  1  ID instruction is a taken jump/branch.
- ex_regfiles_waddr  in  5  destination register of the EX instruction.
- ex_w_regfiles  in  1  EX instruction writes the register file.
- ex_mem_read  in  1  EX instruction is a load.
- ex_div  in  1  EX instruction is a divide.
- pc_en  out  1  PC update enable.
- if_id_en  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID clears to a bubble.
- id_ex_en  out  1  ID/EX load enable.
- id_ex_flush  out  1  ID/EX loads a bubble (all write enables 0).
- div_start  out  1  one-cycle divider start pulse.
- div_busy  out  1  divide sequence in progress.
- stall_cycles  out  32  count of cycles with pc_en=0.

## Operation
- FSM states: RUN, DIV_WAIT. Down-counter cnt, width $clog2(DIV_LAT+1).
- load_use = ex_mem_read & ex_w_regfiles & (ex_regfiles_waddr != 0) & ((id_uses_rs & id_rs_addr == ex_regfiles_waddr) | (id_uses_rt & id_rt_addr == ex_regfiles_waddr)).
- RUN, ex_div=1: div_start=1; pc_en=if_id_en=id_ex_en=0; flushes 0; next DIV_WAIT, cnt <= DIV_LAT-1. If DIV_LAT=1, go straight to the release behaviour next cycle (cnt=0).
- DIV_WAIT, cnt!=0: all enables 0, flushes 0, cnt decrements, div_busy=1.
- DIV_WAIT, cnt==0 (release): div_busy=1, ex_div ignored, load_use/id_isGoto evaluated as in RUN; next RUN.
- RUN (ex_div=0) or release cycle, priority:
  - load_use: pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1, if_id_flush=0.
  - else id_isGoto: all enables 1, if_id_flush=1.
  - else: all enables 1, no flush.
- Load-use beats id_isGoto: the branch waits for its operand and re-resolves next cycle.
- stall_cycles increments (wraps at 2^32) every cycle pc_en=0 outside reset.

## Timing
- Reset (rst=0 at clk edge): state RUN, cnt 0, stall_cycles 0. While rst=0 outputs forced: pc_en=if_id_en=id_ex_en=1, flushes 0, div_start 0, div_busy 0.
- Reset mid-DIV_WAIT: abandons the sequence, RUN next cycle, no further div_start.
- load_use and id_isGoto responses are combinational, same cycle.
- Divide issued in cycle T: front-end stalled T..T+DIV_LAT-1 (DIV_LAT stall cycles); divide leaves EX at end of T+DIV_LAT.
- div_start is high only in cycle T, never during DIV_WAIT.
- Back-to-back divides: a second divide entering EX after the release cycle restarts the sequence with a fresh div_start.
- A load to $0 never stalls.

## Structure
- Shared package pipe_ctrl_pkg: state enum {RUN, DIV_WAIT}, REG_ZERO = 5'd0, DIV_LAT_DEFAULT = 32.
- One sub-module: div_wait_timer (load, decrement, zero flag; parameter DIV_LAT).
- Hazard compare and priority mux stay in the top level.

## Test plan
- Load to $8 in EX, ID reads rs=$8 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1; next cycle no stall; stall_cycles=1.
- Load to $0, ID reads $0 -> no stall; load to $8 with id_uses_rt=0 and rt=$8 -> no stall.
- id_isGoto=1, no hazard -> if_id_flush=1, all enables 1 same cycle.
- id_isGoto=1 with load_use -> stall only, if_id_flush=0; next cycle flush.
- DIV_LAT=4, ex_div at T -> div_start high at T only; enables 0 for T..T+3; enables 1 at T+4; stall_cycles=4.
- rst=0 at T+2 of a DIV_LAT=4 divide -> RUN, div_busy=0, stall_cycles=0 at T+3; no div_start until a new ex_div.
